// File: rtl/miu_ahb_master_pipe.sv
// ----------------------------------------------------------------------------
// miu_ahb_master_pipe
//   Pipelined AHB-Lite master that bridges the MIU request bus to an AHB-Lite
//   slave. The address phase of request N+1 overlaps the data phase of
//   request N. Write data is replicated across all byte lanes. Read data is
//   right-justified and zero-extended. One registered response is returned
//   per transfer, and it carries the HRESP error status. When CANCEL_ON_ERR
//   is set, a pending address phase is retracted on a two-cycle error
//   response and is re-issued afterwards.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   bus_addr/valid/write/size/wdata, bus_ready   request channel
//   resp_valid/rdata/error                       response channel (registered)
//   HCLK, HRESETn, HADDR, HTRANS, HSIZE, HWRITE, HBURST, HMASTLOCK, HWDATA
//                                                AHB-Lite master outputs
//   HRDATA, HREADY, HRESP                        AHB-Lite slave returns
// ----------------------------------------------------------------------------
module miu_ahb_master_pipe #(
  parameter int HADDR_WIDTH   = 17,
  parameter int HDATA_WIDTH   = 64,
  parameter bit CANCEL_ON_ERR = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [HADDR_WIDTH-1:0] bus_addr,
  input  logic                   bus_valid,
  input  logic                   bus_write,
  input  logic [1:0]             bus_size,
  input  logic [HDATA_WIDTH-1:0] bus_wdata,
  output logic                   bus_ready,
  output logic                   resp_valid,
  output logic [HDATA_WIDTH-1:0] resp_rdata,
  output logic                   resp_error,
  output logic                   HCLK,
  output logic                   HRESETn,
  output logic [HADDR_WIDTH-1:0] HADDR,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HSIZE,
  output logic                   HWRITE,
  output logic [2:0]             HBURST,
  output logic                   HMASTLOCK,
  output logic [HDATA_WIDTH-1:0] HWDATA,
  input  logic [HDATA_WIDTH-1:0] HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP
);

  localparam int NBYTES    = HDATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NBYTES);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address-phase stage (A)
  logic                   r_a_valid;
  logic [HADDR_WIDTH-1:0] r_a_addr;
  logic                   r_a_write;
  logic [1:0]             r_a_size;
  logic [HDATA_WIDTH-1:0] r_a_wdata;

  // Data-phase stage (D)
  logic                   r_d_valid;
  logic                   r_d_write;
  logic [1:0]             r_d_size;
  logic [LANE_BITS-1:0]   r_d_lane;
  logic [HDATA_WIDTH-1:0] r_d_wdata;

  // This flag is high during the second cycle of a two-cycle error response.
  // It is only ever set when CANCEL_ON_ERR is enabled.
  logic                   r_err_hold;

  logic                   r_resp_valid;
  logic                   r_resp_error;
  logic [HDATA_WIDTH-1:0] r_resp_rdata;

  logic                   w_bus_ready;
  logic                   w_accept;
  logic                   w_err_first;
  logic                   w_cancel;
  logic                   w_hold_a;
  logic [HDATA_WIDTH-1:0] w_wdata_rep;
  logic [HDATA_WIDTH-1:0] w_rd_shift;
  logic [HDATA_WIDTH-1:0] w_rd_data;

  // The first error cycle is seen while the slave is still stalling the data phase.
  assign w_err_first = r_d_valid & HRESP & ~HREADY;

  // The pending address phase is retracted for both error cycles.
  assign w_cancel    = CANCEL_ON_ERR & r_a_valid & (w_err_first | r_err_hold);

  // When the error completes, A has not been presented to the slave as a
  // valid transfer, so A stays in place instead of advancing.
  assign w_hold_a    = r_err_hold & r_a_valid;

  assign w_bus_ready = ~reset & (~r_a_valid | (HREADY & ~r_err_hold));
  assign w_accept    = bus_valid & w_bus_ready;

  // Write-data lane replication: each output byte takes source byte
  // (byte index mod transfer bytes), so every lane carries the data.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign w_wdata_rep[8*gi +: 8] =
        (bus_size == 2'd0) ? bus_wdata[7:0] :
        (bus_size == 2'd1) ? bus_wdata[8*(gi % 2) +: 8] :
        (bus_size == 2'd2) ? bus_wdata[8*(gi % 4) +: 8] :
                             bus_wdata[8*(gi % 8) +: 8];

      // Bytes beyond the transfer size are zeroed after right-justification.
      assign w_rd_data[8*gi +: 8] =
        (32'(gi) < (32'd1 << r_d_size)) ? w_rd_shift[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign w_rd_shift = HRDATA >> {r_d_lane, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid    <= 1'b0;
      r_a_addr     <= '0;
      r_a_write    <= 1'b0;
      r_a_size     <= 2'd0;
      r_a_wdata    <= '0;
      r_d_valid    <= 1'b0;
      r_d_write    <= 1'b0;
      r_d_size     <= 2'd0;
      r_d_lane     <= '0;
      r_d_wdata    <= '0;
      r_err_hold   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
      r_err_hold   <= CANCEL_ON_ERR & (w_err_first | (r_err_hold & ~HREADY));

      if (HREADY) begin
        if (r_d_valid) begin
          r_resp_valid <= 1'b1;
          r_resp_error <= HRESP;
          r_resp_rdata <= (HRESP | r_d_write) ? '0 : w_rd_data;
        end

        if (w_hold_a) begin
          // A stays in place so that it is re-driven as NONSEQ next cycle.
          r_d_valid <= 1'b0;
        end else begin
          r_d_valid <= r_a_valid;
          r_d_write <= r_a_write;
          r_d_size  <= r_a_size;
          r_d_lane  <= r_a_addr[LANE_BITS-1:0];
          r_d_wdata <= r_a_wdata;
          if (w_accept) begin
            r_a_valid <= 1'b1;
            r_a_addr  <= bus_addr;
            r_a_write <= bus_write;
            r_a_size  <= bus_size;
            r_a_wdata <= w_wdata_rep;
          end else begin
            r_a_valid <= 1'b0;
          end
        end
      end else if (w_accept) begin
        // This is only reachable when A is empty, so nothing is overwritten.
        r_a_valid <= 1'b1;
        r_a_addr  <= bus_addr;
        r_a_write <= bus_write;
        r_a_size  <= bus_size;
        r_a_wdata <= w_wdata_rep;
      end
    end
  end

  assign bus_ready  = w_bus_ready;
  assign resp_valid = r_resp_valid;
  assign resp_error = r_resp_error;
  assign resp_rdata = r_resp_rdata;

  assign HCLK      = clk;
  assign HRESETn   = ~reset;
  assign HADDR     = r_a_addr;
  assign HTRANS    = (r_a_valid & ~w_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSIZE     = {1'b0, r_a_size};
  assign HWRITE    = r_a_write;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = r_d_wdata;

endmodule
